// File: rtl/keypad_pkg.sv
// Shared constants, key-code names and helpers for the keypad scanner.
// Build option: define KEYPAD_REPEAT_EN to enable auto-repeat of a held key.
package keypad_pkg;

  localparam int unsigned KP_ROWS    = 4;
  localparam int unsigned KP_COLS    = 4;
  localparam int unsigned KP_KEYS    = KP_ROWS * KP_COLS;
  localparam int unsigned KEY_CODE_W = 4;

  localparam logic [KP_COLS-1:0] KP_NONE_DRIVEN = 4'b1111;

  // Key codes are {row_idx, col_idx}; these are the ones the controller decodes.
  localparam logic [KEY_CODE_W-1:0] KEY_UP     = 4'h1;
  localparam logic [KEY_CODE_W-1:0] KEY_RUN    = 4'h3;
  localparam logic [KEY_CODE_W-1:0] KEY_LEFT   = 4'h4;
  localparam logic [KEY_CODE_W-1:0] KEY_TOGGLE = 4'h5;
  localparam logic [KEY_CODE_W-1:0] KEY_RIGHT  = 4'h6;
  localparam logic [KEY_CODE_W-1:0] KEY_STEP   = 4'h7;
  localparam logic [KEY_CODE_W-1:0] KEY_DOWN   = 4'h9;
  localparam logic [KEY_CODE_W-1:0] KEY_CLEAR  = 4'hF;

  typedef enum logic {
    SCAN_RESET,
    SCAN_RUN
  } scan_state_e;

  function automatic logic is_single_key(input logic [KP_KEYS-1:0] s);
    return $onehot(s);
  endfunction

  function automatic logic [KEY_CODE_W-1:0] key_index(input logic [KP_KEYS-1:0] s);
    logic [KEY_CODE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < KP_KEYS; i++) begin
      if (s[i]) idx = KEY_CODE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Sweep-level debouncer: accepts a snapshot once it repeats DEBOUNCE_SWEEPS times
// and emits a press event for clean single-key presses (plus repeats with KEYPAD_REPEAT_EN).
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SWEEPS = 3,
  parameter int unsigned REPEAT_SWEEPS   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [KP_KEYS-1:0]    snapshot,
  input  logic                  sweep_end,
  output logic                  evt,
  output logic [KEY_CODE_W-1:0] evt_code,
  output logic                  held
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SWEEPS + 1);

  if (DEBOUNCE_SWEEPS < 1) begin : g_bad_debounce
    $error("DEBOUNCE_SWEEPS must be at least 1");
  end
  if (REPEAT_SWEEPS < 1) begin : g_bad_repeat
    $error("REPEAT_SWEEPS must be at least 1");
  end

  logic [KP_KEYS-1:0] prev_snap;
  logic [KP_KEYS-1:0] stable_state;
  logic [CNT_W-1:0]   stable_cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic               accept;
  logic               press;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    cnt_next = stable_cnt;
    if (snapshot != prev_snap) begin
      cnt_next = CNT_W'(1);
    end else if (stable_cnt != CNT_W'(DEBOUNCE_SWEEPS)) begin
      cnt_next = stable_cnt + 1'b1;
    end
  end

  assign accept = sweep_end && (cnt_next == CNT_W'(DEBOUNCE_SWEEPS)) && (snapshot != stable_state);
  // Only a transition from all-released to exactly one key counts, so key rolls never fire.
  assign press  = accept && is_single_key(snapshot) && (stable_state == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_snap    <= '0;
      stable_state <= '0;
      stable_cnt   <= '0;
    end else if (sweep_end) begin
      prev_snap  <= snapshot;
      stable_cnt <= cnt_next;
      if (accept) stable_state <= snapshot;
    end
  end

  assign held = |stable_state;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RPT_W = $clog2(REPEAT_SWEEPS + 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_armed;
  logic             rpt_fire;

  // Repeats belong to a genuine press; a single key reached by rolling stays disarmed.
  assign rpt_fire = sweep_end && !accept && rpt_armed && (rpt_cnt == RPT_W'(REPEAT_SWEEPS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
    end else if (accept) begin
      rpt_cnt   <= '0;
      rpt_armed <= press;
    end else if (sweep_end && rpt_armed) begin
      rpt_cnt <= rpt_fire ? '0 : rpt_cnt + 1'b1;
    end
  end

  assign evt      = press || rpt_fire;
  assign evt_code = key_index(accept ? snapshot : stable_state);
`else
  assign evt      = press;
  assign evt_code = key_index(snapshot);
`endif

endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner: column drive, row synchronizer, debounce and valid/ack event port.
// Build option: define KEYPAD_REPEAT_EN to enable auto-repeat of a held key.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned COL_CYCLES      = 4,
  parameter int unsigned DEBOUNCE_SWEEPS = 3,
  parameter int unsigned REPEAT_SWEEPS   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [KP_ROWS-1:0]    key_row,
  output logic [KP_COLS-1:0]    key_col,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_valid,
  input  logic                  key_ack,
  output logic                  key_held,
  output logic                  key_ovf
);

  localparam int unsigned WIN_W = $clog2(COL_CYCLES);

  if (COL_CYCLES < 3) begin : g_bad_col_cycles
    $error("COL_CYCLES must be at least 3 to cover synchronizer latency");
  end

  scan_state_e        state;
  scan_state_e        state_next;
  logic [WIN_W-1:0]   win_cnt;
  logic [1:0]         col_idx;
  logic               win_last;
  logic               sweep_end;
  logic [KP_ROWS-1:0] row_meta;
  logic [KP_ROWS-1:0] row_sync;
  logic [KP_KEYS-1:0] snap;
  logic [KP_KEYS-1:0] snap_next;
  logic               evt;
  logic [KEY_CODE_W-1:0] evt_code;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= key_row;
      row_sync <= row_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SCAN_RESET;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    key_col    = KP_NONE_DRIVEN;
    case (state)
      SCAN_RESET: state_next = SCAN_RUN;
      SCAN_RUN:   key_col    = ~(4'b0001 << col_idx);
      default:    state_next = SCAN_RESET;
    endcase
  end

  assign win_last  = (state == SCAN_RUN) && (win_cnt == WIN_W'(COL_CYCLES - 1));
  assign sweep_end = win_last && (col_idx == 2'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_cnt <= '0;
      col_idx <= '0;
    end else if (state == SCAN_RUN) begin
      if (win_last) begin
        win_cnt <= '0;
        col_idx <= col_idx + 2'd1;
      end else begin
        win_cnt <= win_cnt + 1'b1;
      end
    end
  end

  // The debouncer sees snap_next so the column-3 bits sampled at sweep end are included.
  always_comb begin
    snap_next = snap;
    for (int r = 0; r < KP_ROWS; r++) begin
      for (int c = 0; c < KP_COLS; c++) begin
        if (col_idx == 2'(c)) snap_next[r*KP_COLS + c] = ~row_sync[r];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          snap <= '0;
    else if (win_last) snap <= snap_next;
  end

  keypad_debounce #(
    .DEBOUNCE_SWEEPS(DEBOUNCE_SWEEPS),
    .REPEAT_SWEEPS  (REPEAT_SWEEPS)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .snapshot (snap_next),
    .sweep_end(sweep_end),
    .evt      (evt),
    .evt_code (evt_code),
    .held     (key_held)
  );

  // A fresh event may replace one being acked in the same cycle; otherwise it is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      key_ovf   <= 1'b0;
    end else if (evt) begin
      if (!key_valid || key_ack) begin
        key_code  <= evt_code;
        key_valid <= 1'b1;
      end else begin
        key_ovf <= 1'b1;
      end
    end else if (key_ack) begin
      key_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed self-checking bench for keypad_scan with a behavioural active-low key matrix.
module tb_keypad_scan;

  localparam int SWEEP = 16;

  logic       clk;
  logic       rst;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       key_held;
  logic       key_ovf;

  logic [15:0] pressed;
  int checks;
  int failures;

  keypad_scan dut (
    .clk      (clk),
    .rst      (rst),
    .key_row  (key_row),
    .key_col  (key_col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ack  (key_ack),
    .key_held (key_held),
    .key_ovf  (key_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // A pressed key at (r,c) pulls row r low while column c is driven.
  always_comb begin
    key_row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4 + c] && !key_col[c]) key_row[r] = 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Runs for n cycles, acking each event immediately; counts events and wrong codes.
  task automatic count_events(input int n, input logic [3:0] exp_code,
                              output int n_evt, output int n_bad);
    n_evt = 0;
    n_bad = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      key_ack = 1'b0;
      if (key_valid) begin
        n_evt++;
        if (key_code !== exp_code) n_bad++;
        key_ack = 1'b1;
      end
    end
    tick();
    key_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    key_ack = 1'b0;
    pressed = '0;
    repeat (3) tick();
    checks++;
    if (key_col !== 4'b1111) begin
      failures++; $display("FAIL reset_col got=%b exp=1111", key_col);
    end
    checks++;
    if ({key_code, key_valid, key_held, key_ovf} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs got code=%h valid=%b held=%b ovf=%b exp all 0",
               key_code, key_valid, key_held, key_ovf);
    end
  endtask

  task automatic test_idle_scan();
    logic [3:0] exp_col;
    int bad_col;
    int bad_evt;
    rst = 1'b1;
    bad_col = 0;
    bad_evt = 0;
    for (int i = 0; i < 2*SWEEP; i++) begin
      tick();
      exp_col = ~(4'b0001 << ((i / 4) % 4));
      if (i == 0) begin
        checks++;
        if (key_col !== 4'b1110) begin
          failures++; $display("FAIL first_col got=%b exp=1110", key_col);
        end
      end
      if (key_col !== exp_col) begin
        bad_col++;
        $display("FAIL scan_col cycle=%0d got=%b exp=%b", i, key_col, exp_col);
      end
    end
    checks++;
    if (bad_col != 0) failures++;
    for (int i = 0; i < 3*SWEEP; i++) begin
      tick();
      if (key_valid !== 1'b0 || key_held !== 1'b0) bad_evt++;
    end
    checks++;
    if (bad_evt != 0) begin
      failures++; $display("FAIL idle_quiet got=%0d active cycles exp=0", bad_evt);
    end
  endtask

  task automatic test_press();
    int lat;
    int extra;
    logic seen;
    pressed = 16'h0001 << 9;
    seen = 1'b0;
    lat = 0;
    for (int i = 1; i <= 4*SWEEP + 3 && !seen; i++) begin
      tick();
      if (key_valid) begin
        seen = 1'b1;
        lat = i;
      end
    end
    checks++;
    if (!seen) begin
      failures++; $display("FAIL press_latency got=none exp=valid within %0d cycles", 4*SWEEP + 3);
    end
    checks++;
    if (key_code !== 4'h9) begin
      failures++; $display("FAIL press_code got=%h exp=9", key_code);
    end
    checks++;
    if (key_held !== 1'b1) begin
      failures++; $display("FAIL press_held got=%b exp=1", key_held);
    end
    key_ack = 1'b1;
    tick();
    key_ack = 1'b0;
    checks++;
    if (key_valid !== 1'b0) begin
      failures++; $display("FAIL ack_clear got=%b exp=0", key_valid);
    end
    extra = 0;
    for (int i = lat + 1; i < 5*SWEEP; i++) begin
      tick();
      if (key_valid) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++; $display("FAIL held_no_repeat got=%0d valid cycles exp=0", extra);
    end
    pressed = '0;
    repeat (5*SWEEP) tick();
    checks++;
    if (key_held !== 1'b0 || key_valid !== 1'b0) begin
      failures++; $display("FAIL release got held=%b valid=%b exp 0 0", key_held, key_valid);
    end
    // Ack while nothing is pending must not create an event.
    key_ack = 1'b1;
    tick();
    key_ack = 1'b0;
    tick();
    checks++;
    if (key_valid !== 1'b0) begin
      failures++; $display("FAIL stray_ack got=%b exp=0", key_valid);
    end
  endtask

  task automatic test_bounce();
    int n_evt;
    int n_bad;
    int early;
    early = 0;
    pressed = 16'h0040;
    for (int i = 0; i < 10*SWEEP; i++) begin
      tick();
      if (key_valid) early++;
      if ((i % 20) == 19) pressed = pressed ^ 16'h0040;
    end
    checks++;
    if (early != 0) begin
      failures++; $display("FAIL bounce_quiet got=%0d valid cycles exp=0", early);
    end
    pressed = 16'h0040;
    count_events(8*SWEEP, 4'h6, n_evt, n_bad);
    checks++;
    if (n_evt != 1 || n_bad != 0) begin
      failures++; $display("FAIL bounce_event got=%0d events (%0d bad codes) exp=1", n_evt, n_bad);
    end
    pressed = '0;
    count_events(6*SWEEP, 4'h6, n_evt, n_bad);
  endtask

  task automatic test_multi();
    int n_evt;
    int n_bad;
    pressed = (16'h0001 << 3) | (16'h0001 << 12);
    count_events(6*SWEEP, 4'h0, n_evt, n_bad);
    checks++;
    if (key_held !== 1'b1) begin
      failures++; $display("FAIL multi_held got=%b exp=1", key_held);
    end
    pressed = '0;
    count_events(6*SWEEP, 4'h0, n_bad, n_bad);
    n_evt = n_evt + n_bad;
    checks++;
    if (n_evt != 0) begin
      failures++; $display("FAIL multi_event got=%0d events exp=0", n_evt);
    end
    checks++;
    if (key_held !== 1'b0) begin
      failures++; $display("FAIL multi_release got=%b exp=0", key_held);
    end
  endtask

  task automatic test_overflow();
    pressed = 16'h0001 << 5;
    repeat (6*SWEEP) tick();
    checks++;
    if (key_valid !== 1'b1 || key_code !== 4'h5 || key_ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_first got valid=%b code=%h ovf=%b exp 1 5 0", key_valid, key_code, key_ovf);
    end
    pressed = '0;
    repeat (6*SWEEP) tick();
    pressed = 16'h0001 << 7;
    repeat (6*SWEEP) tick();
    checks++;
    if (key_code !== 4'h5) begin
      failures++; $display("FAIL ovf_code got=%h exp=5", key_code);
    end
    checks++;
    if (key_ovf !== 1'b1 || key_valid !== 1'b1) begin
      failures++; $display("FAIL ovf_flag got ovf=%b valid=%b exp 1 1", key_ovf, key_valid);
    end
    pressed = '0;
    key_ack = 1'b1;
    tick();
    key_ack = 1'b0;
    repeat (6*SWEEP) tick();
    checks++;
    if (key_ovf !== 1'b1) begin
      failures++; $display("FAIL ovf_sticky got=%b exp=1", key_ovf);
    end
  endtask

  task automatic test_reset_mid();
    pressed = 16'h0001 << 2;
    repeat (SWEEP + 6) tick();
    #2 rst = 1'b0;
    #1;
    checks++;
    if (key_col !== 4'b1111 || key_valid !== 1'b0 || key_ovf !== 1'b0 || key_held !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got col=%b valid=%b ovf=%b held=%b exp 1111 0 0 0",
               key_col, key_valid, key_ovf, key_held);
    end
    pressed = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (key_col !== 4'b1110) begin
      failures++; $display("FAIL restart_col got=%b exp=1110", key_col);
    end
    repeat (4*SWEEP) tick();
  endtask

`ifdef KEYPAD_REPEAT_EN
  task automatic test_repeat();
    int n_evt;
    int n_bad;
    int n_evt2;
    int n_bad2;
    pressed = 16'h0001;
    count_events(100*SWEEP, 4'h0, n_evt, n_bad);
    pressed = '0;
    count_events(6*SWEEP, 4'h0, n_evt2, n_bad2);
    checks++;
    if (n_evt + n_evt2 != 4 || n_bad + n_bad2 != 0) begin
      failures++;
      $display("FAIL repeat_count got=%0d events (%0d bad codes) exp=4",
               n_evt + n_evt2, n_bad + n_bad2);
    end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_idle_scan();
    test_press();
    test_bounce();
    test_multi();
    test_overflow();
    test_reset_mid();
`ifdef KEYPAD_REPEAT_EN
    test_repeat();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Matrix-scanning input driver for a 4x4 active-low keypad, the input-side companion of the LED matrix row scanner. It drives one keypad column low at a time, samples the row lines, and debounces whole-keypad snapshots. Each clean single-key press becomes a 4-bit key code, offered to the game-of-life control logic over a valid/ack handshake; the controller uses these codes for cursor moves, cell toggles and run/step commands.

## Interface
Parameters:
- COL_CYCLES, 4: clock cycles each column is driven; minimum 3.
- DEBOUNCE_SWEEPS, 3: consecutive identical sweep snapshots needed to accept a new stable state; minimum 1.
- REPEAT_SWEEPS, 32: sweeps between auto-repeat events; used only with KEYPAD_REPEAT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- key_row  in  4  row sense lines, active-low (pulled up), asynchronous to clk
- key_col  out  4  column drive, one-cold; 4'b1111 = none driven
- key_code  out  4  {row_idx[1:0], col_idx[1:0]} of accepted key
- key_valid  out  1  event pending; held until acked
- key_ack  in  1  consumer accepts the event
- key_held  out  1  stable state has at least one key down
- key_ovf  out  1  sticky: an event was dropped

## Operation
- key_row passes through a 2-flop synchronizer before any use.
- Scan: col_idx 0..3, each window COL_CYCLES cycles; key_col = ~(4'b0001 << col_idx).
- Sample: in the last cycle of each window, snapshot bits [r*4+c] = ~row_sync[r] for r = 0..3.
- Sweep end: last cycle of the col 3 window. The 16-bit snapshot is compared with the previous sweep's snapshot.
  - Equal: stable_cnt increments, saturating at DEBOUNCE_SWEEPS.
  - Differ: stable_cnt = 1.
- Accept: when stable_cnt reaches DEBOUNCE_SWEEPS and the snapshot differs from stable_state, stable_state = snapshot.
- Press event: the new stable_state has exactly one bit set and the previous stable_state was all-zero. key_code = index of the set bit.
- Multi-key stable states generate no event. A new event requires all keys released and re-stabilized first, so rolling from one key to another never fires.
- Handshake:
  - An event loads key_code and sets key_valid.
  - key_ack high while key_valid is high clears key_valid on the next edge.
  - key_ack while key_valid is low is ignored.
  - key_code is stable while key_valid is high.
- Simultaneous event and ack: the new event loads and key_valid stays high.
- Event while key_valid is high and un-acked: the event is dropped, key_code is unchanged, and key_ovf is set. key_ovf clears only on reset.
- key_held = |stable_state.

## Timing
- Reset values:
  - key_col = 4'b1111; key_code = 0; key_valid = 0; key_held = 0; key_ovf = 0.
  - Internal state: stable_state = 0, stable_cnt = 0, previous snapshot = 0, col_idx = 0, window counter = 0.
- First edge after rst deasserts: key_col = 4'b1110.
- Sweep length: 4*COL_CYCLES cycles, which is 16 at default.
- Press latency: key_valid rises on the edge after the sweep end that accepts the state.
  - Worst case: DEBOUNCE_SWEEPS+1 sweeps plus 3 cycles after the press edge.
- Reset mid-scan or mid-handshake: everything returns to reset values immediately, any pending event is lost, and scanning restarts at column 0.
- COL_CYCLES of 3 or more ensures the synchronizer output reflects the driven column before sampling.

## Configuration
- KEYPAD_REPEAT_EN defined:
  - While stable_state holds the same single key, a repeat event with the same key_code fires every REPEAT_SWEEPS sweep ends.
  - The repeat count starts at the accept sweep.
  - A repeat event follows the normal handshake and overflow rules.
- KEYPAD_REPEAT_EN undefined: exactly one event per press, and the repeat counter is not built.

## Structure
- Package keypad_pkg:
  - KP_ROWS = 4, KP_COLS = 4.
  - Key code width 4, KP_NONE_DRIVEN = 4'b1111.
  - Named key codes used by the controller: KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT, KEY_TOGGLE, KEY_RUN, KEY_STEP, KEY_CLEAR.
- One sub-module, keypad_debounce:
  - Input: snapshot plus a sweep-end strobe.
  - Contains the stable counter, stable_state, single-key/all-zero detection and the optional repeat counter.
  - Output: an event pulse with its code.
- keypad_scan keeps the column FSM, synchronizer and handshake register.

## Test plan
- Reset, then idle with key_row = 4'hF:
  - key_col cycles 1110, 1101, 1011, 0111, each held for 4 cycles.
  - key_valid stays 0 and key_held stays 0.
- Press row 2 / col 1, driving key_row[2] low only while key_col[1] = 0, held for 5 sweeps:
  - key_valid rises by 4 sweeps + 3 cycles after the press, with key_code = 4'h9.
  - After ack, key_valid falls one cycle later.
  - No second event while held, with the macro off.
- Bounce: toggle the key every 20 cycles for 10 sweeps, then hold steady:
  - No event during bouncing.
  - Exactly one event after 3 steady sweeps.
- Two keys (codes 3 and 12) pressed together, then both released:
  - No event; key_held = 1 during the press.
- Press code 5 and never ack, release, then press code 7:
  - key_code stays 5 and key_ovf = 1.
- Macro on, key 0 held for 100 sweeps with an immediate ack each time:
  - 1 + floor(100/32) = 4 events, all with key_code = 0.
